// File: rtl/crc32_byte_feeder_pkg.sv
// Shared types and constants for the CRC32 byte feeder: register map,
// STATUS bit layout, serializer states and the FIFO entry format.
package crc32_feeder_pkg;

    localparam logic [7:0] ADDR_DATA    = 8'h00;
    localparam logic [7:0] ADDR_LAST    = 8'h01;
    localparam logic [7:0] ADDR_TAIL    = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h03;
    localparam logic [7:0] ADDR_STATUS  = 8'h04;
    localparam logic [7:0] ADDR_BYTECNT = 8'h05;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_LEVEL_LSB = 4;

    typedef enum logic {IDLE, SHIFT} fsm_state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [2:0]  cnt;   // valid bytes in word, 1..4
        logic        last;
    } fifo_entry_t;

    // TAIL encodes a 4-byte tail as 0
    function automatic logic [2:0] tail_cnt(input logic [1:0] tail);
        return (tail == 2'd0) ? 3'd4 : {1'b0, tail};
    endfunction

endpackage

// File: rtl/crc32_byte_feeder_if.sv
// Avalon-MM register port of the CRC32 byte feeder.
interface crc32_byte_feeder_if;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/crc32_byte_feeder_fifo.sv
// Synchronous word FIFO with flush; pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module crc32_feeder_fifo
    import crc32_feeder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  fifo_entry_t              wdata,
    input  logic                     pop,
    input  logic                     flush,
    output fifo_entry_t              rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [AW:0] wr_ptr, rd_ptr;
    fifo_entry_t mem [DEPTH];

    logic do_push, do_pop;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (level == FULL_LVL);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/crc32_byte_feeder.sv
// Avalon-MM word writes -> FIFO -> LSB-first byte stream for a CRC32 engine,
// with frame-end marking and a flush that pulses crc_clear.
module crc32_byte_feeder
    import crc32_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    crc32_byte_feeder_if.slave   avs,
    output logic [7:0]           byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 byte_last,
    output logic                 crc_clear
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    fifo_entry_t push_entry, pop_entry, sh;
    logic        full, empty, push, pop, wr_fifo, flush_wr, hs, last_byte;
    logic [LW-1:0] level;
    logic [1:0]  tail, idx;
    logic [31:0] bytecnt, status_w;
    fsm_state_t  state, state_nxt;

    // Register decode
    assign wr_fifo  = avs.avs_write & ((avs.avs_address == ADDR_DATA) |
                                       (avs.avs_address == ADDR_LAST));
    assign push     = wr_fifo & ~full;
    assign flush_wr = avs.avs_write & (avs.avs_address == ADDR_CTRL) & avs.avs_writedata[0];
    assign avs.avs_waitrequest = wr_fifo & full;

    always_comb begin
        push_entry.word = avs.avs_writedata;
        push_entry.last = (avs.avs_address == ADDR_LAST);
        push_entry.cnt  = push_entry.last ? tail_cnt(tail) : 3'd4;
    end

    crc32_feeder_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (push_entry),
        .pop     (pop),
        .flush   (flush_wr),
        .rdata   (pop_entry),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    always_comb begin
        status_w = '0;
        status_w[ST_EMPTY] = empty;
        status_w[ST_FULL]  = full;
        status_w[ST_BUSY]  = (state == SHIFT);
        status_w[ST_LEVEL_LSB +: LW] = level;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tail      <= '0;
            crc_clear <= 1'b0;
            avs.avs_readdata <= '0;
        end else begin
            crc_clear <= flush_wr;
            if (avs.avs_write && avs.avs_address == ADDR_TAIL)
                tail <= avs.avs_writedata[1:0];
            if (avs.avs_read) begin
                case (avs.avs_address)
                    ADDR_TAIL:    avs.avs_readdata <= {30'd0, tail};
                    ADDR_STATUS:  avs.avs_readdata <= status_w;
                    ADDR_BYTECNT: avs.avs_readdata <= bytecnt;
                    ADDR_DATA, ADDR_LAST, ADDR_CTRL: avs.avs_readdata <= '0;
                    default:      avs.avs_readdata <= '1;
                endcase
            end
        end
    end

    // Serializer
    assign last_byte = ({1'b0, idx} == sh.cnt - 3'd1);
    assign hs        = byte_valid & byte_ready;
    // Reloading on the final handshake keeps the stream bubble-free
    assign pop       = ~flush_wr & ~empty & ((state == IDLE) | (hs & last_byte));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = SHIFT;
            SHIFT:   if (hs && last_byte && empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_wr) state_nxt = IDLE;
    end

    always_comb begin
        byte_valid = (state == SHIFT);
        byte_data  = byte_valid ? sh.word[{idx, 3'b000} +: 8] : 8'd0;
        byte_last  = byte_valid & sh.last & last_byte;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh      <= '0;
            idx     <= '0;
            bytecnt <= '0;
        end else if (flush_wr) begin
            idx     <= '0;
            bytecnt <= '0;
        end else begin
            if (pop) begin
                sh  <= pop_entry;
                idx <= '0;
            end else if (hs) begin
                idx <= idx + 1'b1;
            end
            if (hs) bytecnt <= bytecnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_crc32_byte_feeder.sv
// Directed bench for crc32_byte_feeder: table of single-word frames plus
// hand-written back-pressure, flush and reset sequences.
module tb_crc32_byte_feeder;
    import crc32_feeder_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] byte_data;
    logic       byte_valid, byte_ready, byte_last, crc_clear;

    always #5 clk = ~clk;

    crc32_byte_feeder_if avs_if ();

    crc32_byte_feeder #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .avs        (avs_if),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .crc_clear  (crc_clear)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    // Byte capture: a handshake seen at the negedge completes at the next posedge
    logic [7:0] cap_d [$];
    bit         cap_l [$];
    int         cap_c [$];
    int         cyc = 0;
    bit         stab_en = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'd0;
    logic       prev_l = 1'b0;
    int         stab_err = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset_n && byte_valid && byte_ready) begin
            cap_d.push_back(byte_data);
            cap_l.push_back(byte_last);
            cap_c.push_back(cyc);
        end
        if (stab_en && prev_stall && !(byte_valid && byte_data == prev_d && byte_last == prev_l))
            stab_err <= stab_err + 1;
        prev_stall <= byte_valid & ~byte_ready;
        prev_d     <= byte_data;
        prev_l     <= byte_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, output bit waited, output bit ok);
        waited = 1'b0;
        ok     = 1'b0;
        avs_if.avs_address   = a;
        avs_if.avs_writedata = d;
        avs_if.avs_write     = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (!avs_if.avs_waitrequest) ok = 1'b1;
            else begin
                waited = 1'b1;
                tick();
            end
        end
        tick();
        avs_if.avs_write = 1'b0;
    endtask

    task automatic w(input logic [7:0] a, input logic [31:0] d);
        bit wt, ok;
        wr(a, d, wt, ok);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        avs_if.avs_address = a;
        avs_if.avs_read    = 1'b1;
        tick();
        avs_if.avs_read = 1'b0;
        d = avs_if.avs_readdata;
    endtask

    task automatic wait_bytes(input int n);
        bit got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            if (cap_d.size() >= n) got = 1'b1;
            else tick();
        end
        repeat (3) tick();
    endtask

    function automatic logic [31:0] crc32_cap(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, cap_d[i]};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    typedef struct {
        logic [1:0]  tail;
        logic [31:0] word;
        int          n;
        logic [31:0] exp_bytes;
        logic [3:0]  exp_last;
        bit          crc_chk;
        logic [31:0] exp_crc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vt [4];

    initial begin
        logic [31:0] rdv, act_b;
        logic [3:0]  act_l;
        logic [11:0] rl;
        bit          wt6, ok6, rdone, saw_clr;
        int          err;

        vt[0] = '{2'd0, 32'h6463_6261, 4, 32'h6463_6261, 4'b1000, 1'b1, 32'hED82_CD11, 32'd4};
        vt[1] = '{2'd1, 32'h0000_0031, 1, 32'h0000_0031, 4'b0001, 1'b1, 32'h83DC_EFB7, 32'd5};
        vt[2] = '{2'd2, 32'h0000_BBAA, 2, 32'h0000_BBAA, 4'b0010, 1'b0, 32'd0,         32'd7};
        vt[3] = '{2'd3, 32'h4433_2211, 3, 32'h0033_2211, 4'b0100, 1'b0, 32'd0,         32'd10};

        reset_n = 1'b0;
        byte_ready = 1'b0;
        avs_if.avs_address = '0;
        avs_if.avs_read = 1'b0;
        avs_if.avs_write = 1'b0;
        avs_if.avs_writedata = '0;
        repeat (3) tick();
        chk("rst_readdata", avs_if.avs_readdata, 32'd0);
        chk("rst_outputs", {avs_if.avs_waitrequest, byte_valid, byte_last, crc_clear, byte_data}, 32'd0);
        reset_n = 1'b1;
        tick();
        rd(ADDR_STATUS, rdv);  chk("rst_status", rdv, 32'h1);
        rd(ADDR_TAIL, rdv);    chk("rst_tail", rdv, 32'd0);
        rd(ADDR_BYTECNT, rdv); chk("rst_bytecnt", rdv, 32'd0);

        // Single-word frames with byte_ready held high
        byte_ready = 1'b1;
        foreach (vt[v]) begin
            cap_d.delete(); cap_l.delete(); cap_c.delete();
            w(ADDR_TAIL, {30'd0, vt[v].tail});
            w(ADDR_LAST, vt[v].word);
            chk($sformatf("v%0d_lat_n1", v), {31'd0, byte_valid}, 32'd0);
            tick();
            chk($sformatf("v%0d_lat_n2", v), {31'd0, byte_valid}, 32'd1);
            wait_bytes(vt[v].n);
            chk($sformatf("v%0d_nbytes", v), cap_d.size(), vt[v].n);
            act_b = '0; act_l = '0;
            for (int i = 0; i < cap_d.size() && i < 4; i++) begin
                act_b[8*i +: 8] = cap_d[i];
                act_l[i] = cap_l[i];
            end
            chk($sformatf("v%0d_bytes", v), act_b, vt[v].exp_bytes);
            chk($sformatf("v%0d_last", v), {28'd0, act_l}, {28'd0, vt[v].exp_last});
            if (vt[v].crc_chk)
                chk($sformatf("v%0d_crc", v), crc32_cap(cap_d.size()), vt[v].exp_crc);
            if (cap_d.size() >= vt[v].n)
                chk($sformatf("v%0d_span", v), cap_c[vt[v].n-1] - cap_c[0], vt[v].n - 1);
            rd(ADDR_BYTECNT, rdv);
            chk($sformatf("v%0d_bytecnt", v), rdv, vt[v].exp_cnt);
        end

        // Back-pressure: shift register holds one word, FIFO the next four
        byte_ready = 1'b0;
        cap_d.delete(); cap_l.delete(); cap_c.delete();
        for (int i = 0; i < 5; i++) w(ADDR_DATA, 32'h1000_0000 + i);
        rd(ADDR_STATUS, rdv);
        chk("full_status", rdv, 32'h46);
        fork
            wr(ADDR_DATA, 32'h1000_0005, wt6, ok6);
            begin
                repeat (3) tick();
                byte_ready = 1'b1;
            end
        join
        chk("full_waited", {31'd0, wt6}, 32'd1);
        chk("full_wr_done", {31'd0, ok6}, 32'd1);
        wait_bytes(24);
        chk("full_nbytes", cap_d.size(), 24);
        if (cap_d.size() >= 24) chk("full_span", cap_c[23] - cap_c[0], 23);
        rd(ADDR_BYTECNT, rdv);
        chk("full_bytecnt", rdv, 32'd34);

        // Flush while a byte is presented and stalled
        byte_ready = 1'b0;
        cap_d.delete(); cap_l.delete(); cap_c.delete();
        w(ADDR_DATA, 32'hA4A3_A2A1);
        w(ADDR_DATA, 32'hB4B3_B2B1);
        chk("fl_pre_valid", {23'd0, byte_valid, byte_data}, 32'h1A1);
        w(ADDR_CTRL, 32'h1);
        chk("fl_clear_on", {30'd0, crc_clear, byte_valid}, 32'h2);
        tick();
        chk("fl_clear_off", {31'd0, crc_clear}, 32'd0);
        rd(ADDR_STATUS, rdv);  chk("fl_status", rdv, 32'h1);
        rd(ADDR_BYTECNT, rdv); chk("fl_bytecnt", rdv, 32'd0);
        chk("fl_nbytes", cap_d.size(), 0);

        // Three-word frame under random back-pressure
        w(ADDR_TAIL, 32'd0);
        cap_d.delete(); cap_l.delete(); cap_c.delete();
        stab_en = 1'b1;
        rdone = 1'b0;
        fork
            begin
                for (int k = 0; k < 500 && !rdone; k++) begin
                    byte_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                byte_ready = 1'b1;
            end
            begin
                w(ADDR_DATA, 32'h0403_0201);
                w(ADDR_DATA, 32'h0807_0605);
                w(ADDR_LAST, 32'h0C0B_0A09);
                wait_bytes(12);
                rdone = 1'b1;
            end
        join
        stab_en = 1'b0;
        chk("rnd_nbytes", cap_d.size(), 12);
        err = 0; rl = '0;
        for (int i = 0; i < cap_d.size() && i < 12; i++) begin
            if (cap_d[i] != 8'(i + 1)) err++;
            rl[i] = cap_l[i];
        end
        chk("rnd_order", err, 0);
        chk("rnd_last", {20'd0, rl}, 32'h800);
        chk("rnd_stable", stab_err, 0);
        rd(ADDR_BYTECNT, rdv);
        chk("rnd_bytecnt", rdv, 32'd12);

        // Unmapped read, then asynchronous reset mid-frame
        rd(8'h10, rdv);
        chk("unmapped_rd", rdv, 32'hFFFF_FFFF);
        byte_ready = 1'b0;
        w(ADDR_TAIL, 32'd2);
        w(ADDR_DATA, 32'h55AA_55AA);
        tick();
        chk("ar_pre_valid", {23'd0, byte_valid, byte_data}, 32'h1AA);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_readdata", avs_if.avs_readdata, 32'd0);
        chk("ar_outputs", {avs_if.avs_waitrequest, byte_valid, byte_last, crc_clear, byte_data}, 32'd0);
        tick();
        reset_n = 1'b1;
        saw_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (crc_clear) saw_clr = 1'b1;
        end
        chk("ar_no_clear", {31'd0, saw_clr}, 32'd0);
        rd(ADDR_STATUS, rdv);  chk("ar_status", rdv, 32'h1);
        rd(ADDR_TAIL, rdv);    chk("ar_tail", rdv, 32'd0);
        rd(ADDR_BYTECNT, rdv); chk("ar_bytecnt", rdv, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
